// File: rtl/hard_mem_1rw_byte_mask_banked_pkg.sv
// Shared constants and state type for the banked byte-masked SRAM wrapper.
package hard_mem_pkg;

    localparam int unsigned MACRO_DEPTH      = 1024;
    localparam int unsigned MACRO_WIDTH      = 8;
    localparam int unsigned MACRO_ADDR_WIDTH = 10;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } hard_mem_state_e;

endpackage

// File: rtl/hard_mem_1rw_byte_mask_banked_if.sv
// Request/response bus of the banked byte-masked SRAM wrapper.
interface hard_mem_1rw_byte_mask_banked_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned NUM_WMASKS = DATA_WIDTH / 8
);

    logic                  v_i;
    logic                  w_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [DATA_WIDTH-1:0] data_i;
    logic [NUM_WMASKS-1:0] write_mask_i;
    logic                  ready_o;
    logic                  v_o;
    logic [DATA_WIDTH-1:0] data_o;

    modport master (
        output v_i, w_i, addr_i, data_i, write_mask_i,
        input  ready_o, v_o, data_o
    );

    modport slave (
        input  v_i, w_i, addr_i, data_i, write_mask_i,
        output ready_o, v_o, data_o
    );

endinterface

// File: rtl/hard_mem_1rw_byte_mask_banked_bank_row.sv
// One depth bank: NUM_WMASKS byte-wide macros sharing control and address.
// Power pins exist only when USE_POWER_PINS is defined.
module hard_mem_bank_row
    import hard_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_WMASKS = DATA_WIDTH / MACRO_WIDTH
) (
`ifdef USE_POWER_PINS
    inout  wire                        vccd1,
    inout  wire                        vssd1,
`endif
    input  logic                        clk_i,
    input  logic                        csb0,
    input  logic                        web0,
    input  logic [MACRO_ADDR_WIDTH-1:0] addr0,
    input  logic [NUM_WMASKS-1:0]       wmask0,
    input  logic [DATA_WIDTH-1:0]       din0,
    output logic [DATA_WIDTH-1:0]       dout0
);

    // One macro per byte lane; the read-only port is parked.
    for (genvar l = 0; l < NUM_WMASKS; l++) begin : g_lane
        logic [MACRO_WIDTH-1:0] unused_dout1;

        sky130_sram_1kbyte_1rw1r_8x1024_8 u_sram (
`ifdef USE_POWER_PINS
            .vccd1  (vccd1),
            .vssd1  (vssd1),
`endif
            .clk0   (clk_i),
            .csb0   (csb0),
            .web0   (web0),
            .wmask0 (wmask0[l]),
            .addr0  (addr0),
            .din0   (din0[l*MACRO_WIDTH +: MACRO_WIDTH]),
            .dout0  (dout0[l*MACRO_WIDTH +: MACRO_WIDTH]),
            .clk1   (clk_i),
            .csb1   (1'b1),
            .addr1  ('0),
            .dout1  (unused_dout1)
        );
    end

endmodule

// File: rtl/hard_mem_1rw_byte_mask_banked_sram_macro.sv
// Behavioural stand-in for the sky130 8x1024 1rw1r SRAM macro.
// Both ports are synchronous; dout holds its value between reads.
// Power pins exist only when USE_POWER_PINS is defined.
module sky130_sram_1kbyte_1rw1r_8x1024_8 (
`ifdef USE_POWER_PINS
    inout  wire        vccd1,
    inout  wire        vssd1,
`endif
    input  logic       clk0,
    input  logic       csb0,
    input  logic       web0,
    input  logic [0:0] wmask0,
    input  logic [9:0] addr0,
    input  logic [7:0] din0,
    output logic [7:0] dout0,
    input  logic       clk1,
    input  logic       csb1,
    input  logic [9:0] addr1,
    output logic [7:0] dout1
);

    logic [7:0] array_q [1024];

    // Port 0: masked write or registered read.
    always_ff @(posedge clk0) begin
        if (!csb0) begin
            if (!web0) begin
                if (wmask0[0]) begin
                    array_q[addr0] <= din0;
                end
            end else begin
                dout0 <= array_q[addr0];
            end
        end
    end

    // Port 1: read-only.
    always_ff @(posedge clk1) begin
        if (!csb1) begin
            dout1 <= array_q[addr1];
        end
    end

endmodule

// File: rtl/hard_mem_1rw_byte_mask_banked.sv
// Byte-masked single-port DATA_WIDTH x DEPTH memory built from 8x1024 macros.
// After reset every word is swept to zero before ready_o rises.
// HARD_MEM_OUT_REG_EN adds an output flop stage (read latency 2 instead of 1).
// USE_POWER_PINS exposes vccd1/vssd1 and routes them to every macro.
module hard_mem_1rw_byte_mask_banked
    import hard_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned NUM_WMASKS = DATA_WIDTH / 8
) (
    input  logic clk_i,
    input  logic reset_n_i,
`ifdef USE_POWER_PINS
    inout  wire  vccd1,
    inout  wire  vssd1,
`endif
    hard_mem_1rw_byte_mask_banked_if.slave mem
);

    localparam int unsigned NUM_BANKS  = DEPTH / MACRO_DEPTH;
    localparam int unsigned BANK_WIDTH = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    function automatic logic [BANK_WIDTH-1:0] bank_of(input logic [ADDR_WIDTH-1:0] a);
        return BANK_WIDTH'(a >> MACRO_ADDR_WIDTH);
    endfunction

    hard_mem_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0]       cnt_q, cnt_d;
    logic                        ready_q, ready_d;
    logic                        rd_v_q, rd_v_d;
    logic [BANK_WIDTH-1:0]       bank_q, bank_d;
    logic                        accept_c;

    logic                        m_en;
    logic                        m_web;
    logic [BANK_WIDTH-1:0]       m_bank;
    logic [MACRO_ADDR_WIDTH-1:0] m_addr;
    logic [NUM_WMASKS-1:0]       m_wmask;
    logic [DATA_WIDTH-1:0]       m_din;
    logic [DATA_WIDTH-1:0]       bank_dout [NUM_BANKS];
    logic [DATA_WIDTH-1:0]       rd_data_c;

    assign accept_c = mem.v_i & ready_q;

    // Next-state: zero sweep, then service; track accepted reads and their bank.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        rd_v_d  = 1'b0;
        bank_d  = bank_q;
        case (state_q)
            INIT: begin
                ready_d = 1'b0;
                if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            IDLE: begin
                ready_d = 1'b1;
                if (accept_c && !mem.w_i) begin
                    rd_v_d = 1'b1;
                    bank_d = bank_of(mem.addr_i);
                end
            end
            default: begin
                state_d = INIT;
                ready_d = 1'b0;
            end
        endcase
    end

    // Control and pipeline registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            rd_v_q  <= 1'b0;
            bank_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            rd_v_q  <= rd_v_d;
            bank_q  <= bank_d;
        end
    end

    // Macro request: sweep writes zeros with all lanes, otherwise pass the bus through.
    always_comb begin
        if (state_q == INIT) begin
            m_en    = 1'b1;
            m_web   = 1'b0;
            m_bank  = bank_of(cnt_q);
            m_addr  = MACRO_ADDR_WIDTH'(cnt_q);
            m_wmask = '1;
            m_din   = '0;
        end else begin
            m_en    = accept_c;
            m_web   = ~mem.w_i;
            m_bank  = bank_of(mem.addr_i);
            m_addr  = MACRO_ADDR_WIDTH'(mem.addr_i);
            m_wmask = mem.write_mask_i;
            m_din   = mem.data_i;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        hard_mem_bank_row #(
            .DATA_WIDTH (DATA_WIDTH),
            .NUM_WMASKS (NUM_WMASKS)
        ) u_row (
`ifdef USE_POWER_PINS
            .vccd1  (vccd1),
            .vssd1  (vssd1),
`endif
            .clk_i  (clk_i),
            .csb0   (~(m_en & (m_bank == BANK_WIDTH'(b)))),
            .web0   (m_web),
            .addr0  (m_addr),
            .wmask0 (m_wmask),
            .din0   (m_din),
            .dout0  (bank_dout[b])
        );
    end

    assign rd_data_c    = bank_dout[bank_q];
    assign mem.ready_o  = ready_q;

`ifdef HARD_MEM_OUT_REG_EN
    logic                  v_q;
    logic [DATA_WIDTH-1:0] data_q;

    // Output stage doubles as the read-data hold register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_q    <= 1'b0;
            data_q <= '0;
        end else begin
            v_q <= rd_v_q;
            if (rd_v_q) begin
                data_q <= rd_data_c;
            end
        end
    end

    assign mem.v_o    = v_q;
    assign mem.data_o = data_q;
`else
    logic [DATA_WIDTH-1:0] hold_q;

    // Keep the last read word so data_o is stable between reads.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hold_q <= '0;
        end else if (rd_v_q) begin
            hold_q <= rd_data_c;
        end
    end

    assign mem.v_o    = rd_v_q;
    assign mem.data_o = rd_v_q ? rd_data_c : hold_q;
`endif

endmodule

// File: tb/tb_hard_mem_1rw_byte_mask_banked.sv
// Bench for hard_mem_1rw_byte_mask_banked, DATA_WIDTH=32, DEPTH=2048.
module tb_hard_mem_1rw_byte_mask_banked;

    localparam int DW    = 32;
    localparam int DEPTH = 2048;
    localparam int AW    = 11;
    localparam int NW    = 4;
`ifdef HARD_MEM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    hard_mem_1rw_byte_mask_banked_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

`ifdef USE_POWER_PINS
    wire vccd1 = 1'b1;
    wire vssd1 = 1'b0;
`endif

    hard_mem_1rw_byte_mask_banked #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
`ifdef USE_POWER_PINS
        .vccd1     (vccd1),
        .vssd1     (vssd1),
`endif
        .mem       (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference: word array, cycles left in the sweep, read-latency queue.
    logic [DW-1:0] ref_mem [DEPTH];
    int            init_left;
    logic [DW:0]   pipe [$];
    logic          exp_v;
    logic [DW-1:0] exp_data;

    typedef struct {
        logic          w;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [NW-1:0] mask;
        logic [DW-1:0] exp;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        pipe.delete();
        for (int i = 0; i < LAT - 1; i++) pipe.push_back('0);
        exp_v     = 1'b0;
        exp_data  = '0;
        init_left = DEPTH;
    endtask

    // One clock: drive at negedge, update model at posedge, compare at next negedge.
    task automatic cycle(input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [NW-1:0] m);
        logic        acc;
        logic [DW:0] e;
        bus.v_i          = v;
        bus.w_i          = w;
        bus.addr_i       = a;
        bus.data_i       = d;
        bus.write_mask_i = m;
        chk("ready_o", DW'(bus.ready_o), DW'(init_left == 0));
        acc = v && (init_left == 0);
        @(posedge clk);
        if (acc && w) begin
            for (int k = 0; k < NW; k++)
                if (m[k]) ref_mem[a][8*k +: 8] = d[8*k +: 8];
        end
        pipe.push_back({acc && !w, ref_mem[a]});
        e = pipe.pop_front();
        exp_v = e[DW];
        if (exp_v) exp_data = e[DW-1:0];
        if (init_left > 0) init_left--;
        @(negedge clk);
        chk($sformatf("v_o @%0t", $time), DW'(bus.v_o), DW'(exp_v));
        chk($sformatf("data_o @%0t", $time), bus.data_o, exp_data);
    endtask

    task automatic do_reset(input string name);
        bus.v_i = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk({name, " reset ready_o"}, DW'(bus.ready_o), '0);
        chk({name, " reset v_o"}, DW'(bus.v_o), '0);
        chk({name, " reset data_o"}, bus.data_o, '0);
        repeat (3) begin
            @(negedge clk);
            chk({name, " v_o in reset"}, DW'(bus.v_o), '0);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    // Count cycles with ready_o low while offering a read that must be dropped.
    task automatic wait_ready(input string name);
        int n = 0;
        while (bus.ready_o !== 1'b1 && n < 3 * DEPTH) begin
            cycle(1'b1, 1'b0, AW'(5), '0, '0);
            n++;
        end
        chk({name, " init cycles"}, DW'(n), DW'(DEPTH));
    endtask

    initial begin
        int pulses;
        vecs[0]  = '{1'b1, 11'h005, 32'hDEADBEEF, 4'b1111, 32'h0};
        vecs[1]  = '{1'b1, 11'h005, 32'h11223344, 4'b0101, 32'h0};
        vecs[2]  = '{1'b0, 11'h005, 32'h0,        4'b0000, 32'hDE22BE44};
        vecs[3]  = '{1'b1, 11'h3FF, 32'hA5A50001, 4'b1111, 32'h0};
        vecs[4]  = '{1'b1, 11'h400, 32'h5A5A0002, 4'b1111, 32'h0};
        vecs[5]  = '{1'b0, 11'h3FF, 32'h0,        4'b0000, 32'hA5A50001};
        vecs[6]  = '{1'b0, 11'h400, 32'h0,        4'b0000, 32'h5A5A0002};
        vecs[7]  = '{1'b1, 11'h010, 32'hCAFEF00D, 4'b1111, 32'h0};
        vecs[8]  = '{1'b1, 11'h010, 32'hFFFFFFFF, 4'b0000, 32'h0};
        vecs[9]  = '{1'b0, 11'h010, 32'h0,        4'b0000, 32'hCAFEF00D};
        vecs[10] = '{1'b0, 11'h7FF, 32'h0,        4'b0000, 32'h0};
        vecs[11] = '{1'b1, 11'h7FF, 32'h01020304, 4'b1000, 32'h0};
        vecs[12] = '{1'b0, 11'h7FF, 32'h0,        4'b0000, 32'h01000000};

        bus.v_i = 1'b0; bus.w_i = 1'b0; bus.addr_i = '0;
        bus.data_i = '0; bus.write_mask_i = '0;
        model_reset();

        // Power-on reset and full sweep.
        #1;
        do_reset("por");
        wait_ready("por");

        // Swept memory reads zero.
        cycle(1'b1, 1'b0, 11'h123, '0, '0);
        repeat (LAT - 1) cycle(1'b0, 1'b0, '0, '0, '0);
        chk("first read v_o", DW'(bus.v_o), DW'(1));
        chk("first read data", bus.data_o, '0);

        // Directed vectors.
        for (int i = 0; i < NV; i++) begin
            cycle(1'b1, vecs[i].w, vecs[i].addr, vecs[i].data, vecs[i].mask);
            if (!vecs[i].w) begin
                repeat (LAT - 1) cycle(1'b0, 1'b0, '0, '0, '0);
                chk($sformatf("vec%0d v_o", i), DW'(bus.v_o), DW'(1));
                chk($sformatf("vec%0d data", i), bus.data_o, vecs[i].exp);
            end
        end

        // Read-data hold across writes elsewhere.
        cycle(1'b1, 1'b0, 11'h010, '0, '0);
        pulses = int'(bus.v_o);
        for (int i = 0; i < 5 + LAT - 1; i++) begin
            cycle(1'b1, 1'b1, 11'h020, $urandom, '1);
            pulses += int'(bus.v_o);
        end
        chk("hold v_o pulses", DW'(pulses), DW'(1));
        chk("hold data", bus.data_o, 32'hCAFEF00D);

        // Reset mid-sweep at counter 100.
        do_reset("pre-sweep");
        repeat (100) cycle(1'b0, 1'b0, '0, '0, '0);
        do_reset("mid-sweep");
        wait_ready("mid-sweep");

        // Reset with a read in flight.
        cycle(1'b1, 1'b1, 11'h010, 32'hCAFEF00D, '1);
        bus.v_i = 1'b1; bus.w_i = 1'b0; bus.addr_i = 11'h010;
        @(posedge clk);
        #1;
        do_reset("mid-read");
        wait_ready("mid-read");
        cycle(1'b1, 1'b0, 11'h010, '0, '0);
        repeat (LAT - 1) cycle(1'b0, 1'b0, '0, '0, '0);
        chk("after mid-read reset data", bus.data_o, '0);

        // Random traffic around the bank boundary.
        for (int i = 0; i < 600; i++) begin
            int ai;
            ai = ($urandom_range(0, 1) != 0 ? 1020 : 0) + int'($urandom_range(0, 7));
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, AW'(ai),
                  DW'($urandom), NW'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hard_mem_1rw_byte_mask_banked.md
# hard_mem_1rw_byte_mask_banked

Parametrised byte-masked single-port memory for manycore tile data and instruction storage. Builds a DATA_WIDTH x DEPTH array from 8-bit x 1024-word sky130 SRAM macros, tiled in both width (byte lanes) and depth (banks). Adds behaviour the fixed 1024x32 wrapper lacks:
- post-reset zero-initialisation sweep with a ready handshake;
- a registered valid strobe;
- read-data hold;
- optional output pipeline register.

## Interface
- DATA_WIDTH, 32, word width; multiple of 8, 8..128
- DEPTH, 1024, words; multiple of 1024, 1024..8192
- ADDR_WIDTH, $clog2(DEPTH), address width (derived, do not override)
- NUM_WMASKS, DATA_WIDTH/8, byte lanes (derived)
- clk_i  input  1  clock, all macros and flops
- reset_n_i  input  1  asynchronous, active-low reset
- v_i  input  1  request valid, active high
- w_i  input  1  1 = write, 0 = read; qualified by v_i
- addr_i  input  ADDR_WIDTH  word address
- data_i  input  DATA_WIDTH  write data
- write_mask_i  input  NUM_WMASKS  per-byte write enable, bit k covers data_i[8k+7:8k]
- ready_o  output  1  accepting requests; low during init sweep
- v_o  output  1  read data valid strobe, one cycle per accepted read
- data_o  output  DATA_WIDTH  read data, held between reads
- USE_POWER_PINS builds only: vccd1, vssd1 inout, routed to every macro's matching pin

## Operation
- Bank = addr_i[ADDR_WIDTH-1:10]; row = addr_i[9:0].
- Each bank holds NUM_WMASKS macros. Only the selected bank sees csb0=0; all others are held at csb0=1.
- Port 1 of every macro is unused: csb1 tied 1, addr1 tied 0, dout1 left per-instance and unconnected.
- Request accepted when v_i & ready_o. Requests with ready_o=0 are dropped; the requester must hold them.
- Write: web0=0; wmask0 = write_mask_i lane bit.
  - Mask all-zero is a legal no-op write.
  - A write does not raise v_o and does not change data_o.
- Read: web0=1. The bank index is registered, and that registered index muxes the macro dout0 buses.
- FSM states:
  - INIT: reset value. A counter 0..DEPTH-1 writes zero to every address, all masks on, one address per cycle. ready_o=0. Exits to IDLE after address DEPTH-1 is written.
  - IDLE: ready_o=1, normal service. The only exit is reset.
- Hold register captures the muxed read data on each v_o cycle. When v_o=0, data_o = hold register.
- Back-to-back reads every cycle are supported.
- Read-after-write to the same address in consecutive cycles returns the new data.
- Reset values: ready_o=0, v_o=0, data_o=0, hold=0, counter=0, state INIT.
- Reset asserted mid-sweep or mid-read: return to INIT, restart the sweep from 0, drop the in-flight read (no v_o).

## Timing
- Write accepted at edge N: memory updated at edge N.
- Read accepted at edge N: v_o=1 and data_o valid during cycle N+1. With HARD_MEM_OUT_REG_EN, this moves to cycle N+2.
- Init sweep lasts exactly DEPTH cycles after reset deassertion. ready_o rises in the cycle after the last sweep write.
- Reset deassertion is synchronised externally; the block relies on its first post-reset edge being clean.

## Configuration
- HARD_MEM_OUT_REG_EN defined:
  - Adds a flop stage on the muxed data and on v_o, so read latency is 2.
  - The hold register is the output flop itself.
  - Eases the macro clock-to-out path into tile logic.
- Undefined: read latency 1; data_o is the combinational bank mux when v_o=1, otherwise the hold register.

## Structure
- Package hard_mem_pkg:
  - MACRO_DEPTH=1024, MACRO_WIDTH=8, MACRO_ADDR_WIDTH=10;
  - state enum hard_mem_state_e {INIT, IDLE}.
- Sub-module hard_mem_bank_row: one depth bank of NUM_WMASKS macros.
  - Shared csb0/web0/addr0.
  - Per-lane wmask0/din0.
  - Concatenated dout.
  - Instantiated DEPTH/1024 times by generate.
- Top holds FSM, sweep counter, bank-select register, output mux and hold register.

## Test plan
- Reset, DATA_WIDTH=32, DEPTH=2048 -> ready_o low for exactly 2048 cycles. Then read any address -> 0x00000000 with v_o one cycle later.
- Write 0xDEADBEEF to addr 0x005, mask 4'b1111, then write 0x11223344 mask 4'b0101 -> read returns 0xDE22BE44.
- Write distinct data to addr 0x3FF (bank 0) and 0x400 (bank 1), back-to-back reads -> v_o on consecutive cycles with correct per-bank data.
- Read 0xCAFEF00D, then idle 5 cycles while writing another address -> data_o stays 0xCAFEF00D, v_o pulses once.
- Assert reset_n_i low mid-sweep at counter 100 and again during an outstanding read -> no v_o, sweep restarts, full DEPTH-cycle init observed.
- With HARD_MEM_OUT_REG_EN: read issued at edge N -> v_o and data at N+2; repeat the mask test, same results.
